// File: rtl/text_console_ctrl.sv
// Custom-instruction text console: colour/cursor registers, character FIFO and a drain FSM writing text RAM.
// Optional edit characters (backspace, tab) are enabled by defining TEXT_CONSOLE_CTRL_EDIT_EN.
//
// state        | meaning
// S_IDLE       | waiting; pops one character when the FIFO is non-empty
// S_PUT        | one cycle handling the popped character
// S_CLR_LINE   | writing blanks across the new bottom row after a scroll
// S_CLR_SCREEN | writing blanks to every cell, then homing cursor and scroll
module text_console_ctrl #(
  parameter int          NR_COLS    = 80,
  parameter int          NR_ROWS    = 45,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  CI_NR      = 8'd0,
  parameter logic [15:0] DEFAULT_FG = 16'hFFFF,
  parameter logic [15:0] DEFAULT_BG = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciDataA,
  input  logic [31:0] ciDataB,
  input  logic        ciStart,
  input  logic        ciCke,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic        ramWe,
  output logic [12:0] ramAddress,
  output logic [7:0]  ramData,
  output logic [6:0]  cursorX,
  output logic [6:0]  cursorY,
  output logic [12:0] scrollOffset,
  output logic [15:0] foreGroundColor,
  output logic [15:0] backGroundColor,
  output logic        cursorVisible
);

  localparam int          TOTAL     = NR_COLS * NR_ROWS;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [13:0] TOTAL_W   = 14'(TOTAL);
  localparam logic [6:0]  LAST_COL  = 7'(NR_COLS - 1);
  localparam logic [6:0]  LAST_ROW  = 7'(NR_ROWS - 1);
  localparam logic [12:0] CLR_LAST  = 13'(TOTAL - 1);
  localparam logic [12:0] LINE_LAST = 13'(NR_COLS - 1);
  localparam logic [PW:0] FULL_LVL  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PUT, S_CLR_LINE, S_CLR_SCREEN} state_t;

  state_t        state_q, state_d;
  logic [12:0]   cnt_q, cnt_d;
  logic [6:0]    x_q, x_d, y_q, y_d;
  logic [12:0]   scroll_q, scroll_d;
  logic [15:0]   fg_q, fg_d, bg_q, bg_d;
  logic          vis_q, vis_d;
  logic [7:0]    char_q, char_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   fill_q, fill_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic        ci_active, full, empty, push, pop, flush, advance, we, use_cnt_addr, done;
  logic [3:0]  opcode;
  logic [7:0]  wdata;
  logic [6:0]  addr_col, addr_row;
  logic [13:0] addr_sum, scroll_sum;
  logic [12:0] addr_wr, scroll_next;
  logic [31:0] result;
  logic        unused_bits;
`ifdef TEXT_CONSOLE_CTRL_EDIT_EN
  logic [7:0]  tab_x;
`endif

  assign unused_bits = ^{ciDataA[31:4], ciDataB[31:16]};
  assign ci_active   = (ciN == CI_NR) && ciStart && ciCke;
  assign opcode      = ciDataA[3:0];
  assign full        = (fill_q == FULL_LVL);
  assign empty       = (fill_q == '0);

  // Operands stay below TOTAL, so one conditional subtract is a full modulo.
  assign addr_sum    = {1'b0, scroll_q} + 14'(addr_row) * 14'(NR_COLS) + 14'(addr_col);
  assign addr_wr     = (addr_sum >= TOTAL_W) ? 13'(addr_sum - TOTAL_W) : addr_sum[12:0];
  assign scroll_sum  = {1'b0, scroll_q} + 14'(NR_COLS);
  assign scroll_next = (scroll_sum >= TOTAL_W) ? 13'(scroll_sum - TOTAL_W) : scroll_sum[12:0];

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; x_d = x_q; y_d = y_q; scroll_d = scroll_q;
    fg_d = fg_q; bg_d = bg_q; vis_d = vis_q; char_d = char_q;
    push = 1'b0; pop = 1'b0; flush = 1'b0; advance = 1'b0; we = 1'b0;
    use_cnt_addr = 1'b0; done = 1'b0; result = '0;
    wdata = 8'h20; addr_col = x_q; addr_row = y_q;
`ifdef TEXT_CONSOLE_CTRL_EDIT_EN
    tab_x = {1'b0, x_q[6:3], 3'b000} + 8'd8;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          char_d  = fifo_mem[rd_ptr_q];
          state_d = S_PUT;
        end
      end
      S_PUT: begin
        state_d = S_IDLE;
        case (char_q)
          8'h0A: begin x_d = '0; advance = 1'b1; end
          8'h0D: x_d = '0;
`ifdef TEXT_CONSOLE_CTRL_EDIT_EN
          8'h08: begin
            if (x_q != '0) begin
              x_d = x_q - 7'd1; addr_col = x_q - 7'd1; we = 1'b1;
            end else if (y_q != '0) begin
              x_d = LAST_COL; y_d = y_q - 7'd1;
              addr_col = LAST_COL; addr_row = y_q - 7'd1; we = 1'b1;
            end
          end
          8'h09: begin
            if (tab_x > {1'b0, LAST_COL}) begin x_d = '0; advance = 1'b1; end
            else x_d = tab_x[6:0];
          end
`endif
          default: begin
            we = 1'b1; wdata = char_q;
            if (x_q == LAST_COL) begin x_d = '0; advance = 1'b1; end
            else x_d = x_q + 7'd1;
          end
        endcase
        if (advance) begin
          if (y_q != LAST_ROW) y_d = y_q + 7'd1;
          else begin
            scroll_d = scroll_next; cnt_d = '0; state_d = S_CLR_LINE;
          end
        end
      end
      S_CLR_LINE: begin
        we = 1'b1; addr_col = cnt_q[6:0]; cnt_d = cnt_q + 13'd1;
        if (cnt_q == LINE_LAST) state_d = S_IDLE;
      end
      default: begin
        we = 1'b1; use_cnt_addr = 1'b1; cnt_d = cnt_q + 13'd1;
        if (cnt_q == CLR_LAST) begin
          x_d = '0; y_d = '0; scroll_d = '0; state_d = S_IDLE;
        end
      end
    endcase

    // Instruction decode last so a clear overrides whatever the drain FSM chose.
    if (ci_active) begin
      case (opcode)
        4'h0: begin fg_d = ciDataB[15:0]; done = 1'b1; end
        4'h1: begin bg_d = ciDataB[15:0]; done = 1'b1; end
        4'h2: begin
          if (!full || pop) begin push = 1'b1; done = 1'b1; end
        end
        4'h3: begin flush = 1'b1; state_d = S_CLR_SCREEN; cnt_d = '0; done = 1'b1; end
        4'h4: begin
          if (state_q == S_IDLE && empty) begin
            // Any X with bit 7 set is past every legal column, so clamp on the full byte.
            x_d  = (ciDataB[7:0] > {1'b0, LAST_COL}) ? LAST_COL : ciDataB[6:0];
            y_d  = (ciDataB[14:8] > LAST_ROW) ? LAST_ROW : ciDataB[14:8];
            done = 1'b1;
          end
        end
        4'h5: begin vis_d = ciDataB[0]; done = 1'b1; end
        4'h8: begin result = {16'd0, fg_q}; done = 1'b1; end
        4'h9: begin result = {16'd0, bg_q}; done = 1'b1; end
        4'hC: begin result = {9'd0, y_q, 9'd0, x_q}; done = 1'b1; end
        4'hD: begin result = {{(31 - PW){1'b0}}, fill_q}; done = 1'b1; end
        4'hF: begin result = {9'd0, 7'(NR_ROWS), 9'd0, 7'(NR_COLS)}; done = 1'b1; end
        default: done = 1'b1;
      endcase
    end

    if (flush) begin
      wr_ptr_d = '0; rd_ptr_d = '0; fill_d = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fill_d   = fill_q + (PW + 1)'(push) - (PW + 1)'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_CLR_SCREEN; cnt_q <= '0;
      x_q <= '0; y_q <= '0; scroll_q <= '0;
      fg_q <= DEFAULT_FG; bg_q <= DEFAULT_BG; vis_q <= 1'b1; char_q <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; fill_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;
      x_q <= x_d; y_q <= y_d; scroll_q <= scroll_d;
      fg_q <= fg_d; bg_q <= bg_d; vis_q <= vis_d; char_q <= char_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fill_q <= fill_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) fifo_mem[wr_ptr_q] <= ciDataB[7:0];
  end

  assign ciDone          = done && !reset;
  assign ciResult        = result;
  assign ramWe           = we && !reset;
  assign ramAddress      = use_cnt_addr ? cnt_q : addr_wr;
  assign ramData         = wdata;
  assign cursorX         = x_q;
  assign cursorY         = y_q;
  assign scrollOffset    = scroll_q;
  assign foreGroundColor = fg_q;
  assign backGroundColor = bg_q;
  assign cursorVisible   = vis_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized bench for text_console_ctrl against a behavioural console model (cursor, scroll, RAM write stream).
module tb_text_console_ctrl;
  localparam int COLS = 80, ROWS = 45, TOTAL = COLS * ROWS, BUDGET = 8000;

  logic        clock = 1'b0, reset = 1'b1;
  logic [7:0]  ciN = '0;
  logic [31:0] ciDataA = '0, ciDataB = '0;
  logic        ciStart = 1'b0, ciCke = 1'b1;
  logic        ciDone, ramWe, cursorVisible;
  logic [31:0] ciResult;
  logic [12:0] ramAddress, scrollOffset;
  logic [7:0]  ramData;
  logic [6:0]  cursorX, cursorY;
  logic [15:0] foreGroundColor, backGroundColor;

  text_console_ctrl #(.NR_COLS(COLS), .NR_ROWS(ROWS), .FIFO_DEPTH(8), .CI_NR(8'd0),
                      .DEFAULT_FG(16'hFFFF), .DEFAULT_BG(16'h0000)) dut (
    .clock(clock), .reset(reset), .ciN(ciN), .ciDataA(ciDataA), .ciDataB(ciDataB),
    .ciStart(ciStart), .ciCke(ciCke), .ciDone(ciDone), .ciResult(ciResult),
    .ramWe(ramWe), .ramAddress(ramAddress), .ramData(ramData),
    .cursorX(cursorX), .cursorY(cursorY), .scrollOffset(scrollOffset),
    .foreGroundColor(foreGroundColor), .backGroundColor(backGroundColor),
    .cursorVisible(cursorVisible));

  always #5 clock = ~clock;

  int n_checks = 0, n_pass = 0;
  int m_x, m_y, m_scroll;
  logic [20:0] exp_q [$];
  logic [20:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected RAM writes, in order, derived from cursor/scroll rules.
  task automatic push_wr(input int x, input int y, input logic [7:0] d);
    exp_q.push_back({13'((m_scroll + y * COLS + x) % TOTAL), d});
  endtask

  task automatic model_clear();
    for (int i = 0; i < TOTAL; i++) exp_q.push_back({13'(i), 8'h20});
    m_x = 0; m_y = 0; m_scroll = 0;
  endtask

  task automatic model_put(input logic [7:0] ch);
    bit adv = 0;
    int nx;
    case (ch)
      8'h0A: begin m_x = 0; adv = 1; end
      8'h0D: m_x = 0;
`ifdef TEXT_CONSOLE_CTRL_EDIT_EN
      8'h08: begin
        if (m_x > 0) begin m_x--; push_wr(m_x, m_y, 8'h20); end
        else if (m_y > 0) begin m_x = COLS - 1; m_y--; push_wr(m_x, m_y, 8'h20); end
      end
      8'h09: begin
        nx = (m_x / 8 + 1) * 8;
        if (nx > COLS - 1) begin m_x = 0; adv = 1; end else m_x = nx;
      end
`endif
      default: begin
        push_wr(m_x, m_y, ch);
        if (m_x == COLS - 1) begin m_x = 0; adv = 1; end else m_x++;
      end
    endcase
    if (adv) begin
      if (m_y < ROWS - 1) m_y++;
      else begin
        m_scroll = (m_scroll + COLS) % TOTAL;
        for (int c = 0; c < COLS; c++) push_wr(c, ROWS - 1, 8'h20);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset && ramWe) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr_data", {11'd0, ramAddress, ramData}, {11'd0, mon_e});
      end
    end
  end

  task automatic ci_cmd(input logic [3:0] op, input logic [31:0] b,
                        output logic [31:0] res, output logic done, output int waited);
    @(posedge clock); #1;
    ciN = 8'd0; ciCke = 1'b1; ciStart = 1'b1; ciDataA = {28'd0, op}; ciDataB = b;
    waited = 0;
    @(negedge clock);
    while (!ciDone && waited < BUDGET) begin @(negedge clock); waited++; end
    done = ciDone; res = ciResult;
    @(posedge clock); #1;
    ciStart = 1'b0; ciDataA = '0; ciDataB = '0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [31:0] b, output logic [31:0] res);
    logic d; int w;
    ci_cmd(op, b, res, d, w);
    check($sformatf("done_op%0h", op), 32'(d), 32'd1);
  endtask

  task automatic enq(input logic [7:0] ch);
    logic [31:0] r;
    model_put(ch);
    cmd(4'h2, {24'd0, ch}, r);
  endtask

  task automatic set_cursor(input int x, input int y);
    logic [31:0] r;
    m_x = (x > COLS - 1) ? COLS - 1 : x;
    m_y = (y > ROWS - 1) ? ROWS - 1 : y;
    cmd(4'h4, {17'd0, 7'(y), 8'(x)}, r);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clock); n++; end
    check("drain", 32'(exp_q.size() == 0), 32'd1);
    repeat (20) @(negedge clock);
  endtask

  task automatic check_cursor(input string tag);
    logic [31:0] r;
    cmd(4'hC, 32'd0, r);
    check(tag, r, {9'd0, 7'(m_y), 9'd0, 7'(m_x)});
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, v;
    logic d;
    int w, sel;
    logic [7:0] ch;

    ciStart = 1'b1; ciDataA = 32'h8;
    repeat (3) @(negedge clock);
    check("rst_done", 32'(ciDone), 32'd0);
    check("rst_we", 32'(ramWe), 32'd0);
    check("rst_xy", {18'd0, cursorY, cursorX}, 32'd0);
    check("rst_scroll", 32'(scrollOffset), 32'd0);
    check("rst_fg", 32'(foreGroundColor), 32'hFFFF);
    check("rst_bg", 32'(backGroundColor), 32'h0000);
    check("rst_vis", 32'(cursorVisible), 32'd1);
    ciStart = 1'b0; ciDataA = '0;

    model_clear();
    @(posedge clock); #1 reset = 1'b0;

    // Fill the FIFO while the power-on clear holds the drain off.
    enq(8'h41); enq(8'h42);
    for (int i = 0; i < 6; i++) enq(8'($urandom_range(32, 126)));
    cmd(4'hD, 32'd0, r);
    check("fill_8", r, 32'd8);
    ch = 8'($urandom_range(32, 126));
    model_put(ch);
    ci_cmd(4'h2, {24'd0, ch}, r, d, w);
    check("enq9_done", 32'(d), 32'd1);
    check("enq9_stalled", 32'(w > 1000), 32'd1);
    wait_drain();
    check("after_clr_x", 32'(cursorX), 32'(m_x));
    check("after_clr_y", 32'(cursorY), 32'(m_y));

    // Character at the last cell scrolls and blanks the new bottom row.
    set_cursor(79, 44);
    enq(8'h5A);
    wait_drain();
    check("scroll_80", 32'(scrollOffset), 32'(m_scroll));
    check_cursor("cursor_after_scroll");

    set_cursor(200, 3);
    check_cursor("clamp_200_3");
`ifdef TEXT_CONSOLE_CTRL_EDIT_EN
    set_cursor(0, 3);
    enq(8'h08);
    wait_drain();
    check_cursor("bs_wrap");
`endif

    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      cmd(4'h0, v, r); cmd(4'h8, 32'd0, r);
      check("fg_read", r, {16'd0, v[15:0]});
      check("fg_out", 32'(foreGroundColor), {16'd0, v[15:0]});
      v = $urandom;
      cmd(4'h1, v, r); cmd(4'h9, 32'd0, r);
      check("bg_read", r, {16'd0, v[15:0]});
      cmd(4'h5, 32'(i & 1), r);
      check("vis_out", 32'(cursorVisible), 32'(i & 1));
    end
    cmd(4'hF, 32'd0, r);
    check("geometry", r, (32'(ROWS) << 16) | 32'(COLS));
    cmd(4'h6, 32'hFFFF_FFFF, r);
    check("nop_result", r, 32'd0);

    @(posedge clock); #1;
    ciN = 8'h05; ciStart = 1'b1; ciDataA = 32'h8;
    @(negedge clock);
    check("wrong_ci_done", {31'd0, ciDone}, 32'd0);
    check("wrong_ci_result", ciResult, 32'd0);
    ciN = 8'h00; ciCke = 1'b0;
    @(negedge clock);
    check("no_cke_done", {31'd0, ciDone}, 32'd0);
    @(posedge clock); #1;
    ciStart = 1'b0; ciCke = 1'b1; ciDataA = '0;

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) set_cursor($urandom_range(0, 200), $urandom_range(0, 100));
      else if (sel == 1) begin wait_drain(); check_cursor("rand_cursor"); end
      else begin
        sel = $urandom_range(0, 15);
        case (sel)
          0: ch = 8'h0A;
          1: ch = 8'h0D;
          2: ch = 8'h08;
          3: ch = 8'h09;
          default: ch = 8'($urandom_range(32, 126));
        endcase
        enq(ch);
      end
    end
    wait_drain();
    check_cursor("rand_end_cursor");
    check("rand_end_scroll", 32'(scrollOffset), 32'(m_scroll));

    model_clear();
    cmd(4'h3, 32'd0, r);
    wait_drain();
    check_cursor("clear_home");
    check("clear_scroll", 32'(scrollOffset), 32'd0);
    check("idle_result", ciResult, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
